// File: rtl/motor_ramp_sequencer.sv
// Motor speed ramp sequencer: one-step speed ramps, dead time on reversal,
// level-sensitive emergency stop; every output is registered.
module motor_ramp_sequencer #(
   parameter int RAMP_TICKS = 1000000,
   parameter int DEAD_TICKS = 500000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_speed,
   input  logic       cmd_dir,
   input  logic       estop,
   output logic [1:0] pwm_speed,
   output logic       pwm_on,
   output logic       motor_dir,
   output logic       busy
);

   localparam int MAXT = (RAMP_TICKS > DEAD_TICKS) ? RAMP_TICKS : DEAD_TICKS;
   localparam int CW = $clog2(MAXT + 1);

   typedef enum logic [2:0] {
      IDLE,
      RAMP_UP,
      RAMP_DOWN,
      DEADTIME,
      HOLD
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [1:0]    target_speed, target_speed_n;
   logic [1:0]    speed_n;
   logic          target_dir, target_dir_n;
   logic          dir_n;
   logic          accept;
   logic          ramp_wrap;
   logic          dead_wrap;

   always_comb begin
      state_n        = state;
      cnt_n          = cnt;
      speed_n        = pwm_speed;
      dir_n          = motor_dir;
      target_speed_n = target_speed;
      target_dir_n   = target_dir;
      accept         = cmd_valid && cmd_ready && !estop;
      ramp_wrap      = (cnt == CW'(RAMP_TICKS - 1));
      dead_wrap      = (cnt == CW'(DEAD_TICKS - 1));

      if (estop) begin
         state_n        = IDLE;
         speed_n        = 2'd0;
         target_speed_n = 2'd0;
         cnt_n          = '0;
      end else begin
         unique case (state)
            IDLE, HOLD: begin
               if (accept) begin
                  target_speed_n = cmd_speed;
                  target_dir_n   = cmd_dir;
                  if (cmd_dir != motor_dir)
                     state_n = (pwm_speed != 2'd0) ? RAMP_DOWN : DEADTIME;
                  else if (cmd_speed > pwm_speed)
                     state_n = RAMP_UP;
                  else if (cmd_speed < pwm_speed)
                     state_n = RAMP_DOWN;
                  else
                     state_n = (cmd_speed != 2'd0) ? HOLD : IDLE;
               end
            end
            RAMP_UP: begin
               cnt_n = cnt + 1'b1;
               if (ramp_wrap) begin
                  cnt_n = '0;
                  if (pwm_speed != 2'd3)
                     speed_n = pwm_speed + 2'd1;
                  if (speed_n >= target_speed)
                     state_n = HOLD;
               end
            end
            RAMP_DOWN: begin
               cnt_n = cnt + 1'b1;
               if (ramp_wrap) begin
                  cnt_n = '0;
                  if (pwm_speed != 2'd0)
                     speed_n = pwm_speed - 2'd1;
                  // a pending reversal always ramps all the way to zero
                  if (target_dir != motor_dir) begin
                     if (speed_n == 2'd0)
                        state_n = DEADTIME;
                  end else if (speed_n <= target_speed) begin
                     state_n = (target_speed == 2'd0) ? IDLE : HOLD;
                  end
               end
            end
            DEADTIME: begin
               speed_n = 2'd0;
               cnt_n   = cnt + 1'b1;
               if (dead_wrap) begin
                  dir_n   = target_dir;
                  state_n = (target_speed != 2'd0) ? RAMP_UP : IDLE;
               end
            end
            default: state_n = IDLE;
         endcase
         if (state_n != state)
            cnt_n = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         pwm_speed    <= 2'd0;
         pwm_on       <= 1'b0;
         motor_dir    <= 1'b0;
         target_speed <= 2'd0;
         target_dir   <= 1'b0;
         busy         <= 1'b0;
         cmd_ready    <= 1'b1;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         pwm_speed    <= speed_n;
         pwm_on       <= (speed_n != 2'd0);
         motor_dir    <= dir_n;
         target_speed <= target_speed_n;
         target_dir   <= target_dir_n;
         busy         <= (state_n inside {RAMP_UP, RAMP_DOWN, DEADTIME});
         cmd_ready    <= (state_n == IDLE || state_n == HOLD) && !estop;
      end
   end

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Scoreboard bench for motor_ramp_sequencer: expected output snapshots are
// queued by cycle number and checked by an independent monitor.
module tb_motor_ramp_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_speed = 2'd0;
   logic       cmd_dir = 1'b0;
   logic       estop = 1'b0;
   logic [1:0] pwm_speed;
   logic       pwm_on;
   logic       motor_dir;
   logic       busy;

   int cyc = 0;
   int total = 0;
   int bad = 0;

   typedef struct {
      int         c;
      string      n;
      logic [5:0] v;
   } exp_t;

   exp_t q[$];

   motor_ramp_sequencer #(
      .RAMP_TICKS(4),
      .DEAD_TICKS(3)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_speed(cmd_speed),
      .cmd_dir  (cmd_dir),
      .estop    (estop),
      .pwm_speed(pwm_speed),
      .pwm_on   (pwm_on),
      .motor_dir(motor_dir),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // snapshot order: {pwm_speed, pwm_on, motor_dir, busy, cmd_ready}
   function automatic void ex(input int c, input string n,
                              input logic [1:0] s, input logic on,
                              input logic d, input logic b, input logic r);
      exp_t e;
      e.c = c;
      e.n = n;
      e.v = {s, on, d, b, r};
      q.push_back(e);
   endfunction

   always @(negedge clk) begin
      logic [5:0] act;
      exp_t e;
      act = {pwm_speed, pwm_on, motor_dir, busy, cmd_ready};
      while (q.size() > 0 && q[0].c <= cyc) begin
         e = q.pop_front();
         total++;
         if (e.c != cyc || act !== e.v) begin
            bad++;
            $display("FAIL %s cyc=%0d want_cyc=%0d got=%b want=%b",
                     e.n, cyc, e.c, act, e.v);
         end
      end
   end

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic pulse_cmd(input logic [1:0] s, input logic d);
      cmd_valid = 1'b1;
      cmd_speed = s;
      cmd_dir   = d;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   initial begin
      int t;
      ex(2, "reset_vals", 2'd0, 0, 0, 0, 1);
      ex(4, "ready_after_rel", 2'd0, 0, 0, 0, 1);
      wait_cyc(3);
      reset = 1'b0;

      // ramp up to 3 while a different command is held off by busy
      wait_cyc(6);
      t = cyc;
      ex(t + 1, "up_enter", 2'd0, 0, 0, 1, 0);
      ex(t + 4, "up_no_early", 2'd0, 0, 0, 1, 0);
      ex(t + 5, "up_s1", 2'd1, 1, 0, 1, 0);
      ex(t + 9, "up_s2", 2'd2, 1, 0, 1, 0);
      ex(t + 13, "up_hold3", 2'd3, 1, 0, 0, 1);
      ex(t + 14, "held_cmd_acc", 2'd3, 1, 0, 1, 0);
      ex(t + 18, "down_hold2", 2'd2, 1, 0, 0, 1);
      cmd_valid = 1'b1;
      cmd_speed = 2'd3;
      cmd_dir   = 1'b0;
      @(negedge clk);
      cmd_speed = 2'd2;
      wait_cyc(t + 14);
      cmd_valid = 1'b0;
      wait_cyc(t + 20);

      // reversal from speed 2 fwd to speed 1 rev
      t = cyc;
      ex(t + 1, "rev_enter", 2'd2, 1, 0, 1, 0);
      ex(t + 5, "rev_s1", 2'd1, 1, 0, 1, 0);
      ex(t + 9, "rev_s0", 2'd0, 0, 0, 1, 0);
      ex(t + 11, "rev_dead", 2'd0, 0, 0, 1, 0);
      ex(t + 12, "rev_dir", 2'd0, 0, 1, 1, 0);
      ex(t + 15, "rev_wait", 2'd0, 0, 1, 1, 0);
      ex(t + 16, "rev_hold1", 2'd1, 1, 1, 0, 1);
      pulse_cmd(2'd1, 1'b1);
      wait_cyc(t + 18);

      // up to 3 then ramp down to zero
      t = cyc;
      ex(t + 5, "c_s2", 2'd2, 1, 1, 1, 0);
      ex(t + 9, "c_hold3", 2'd3, 1, 1, 0, 1);
      pulse_cmd(2'd3, 1'b1);
      wait_cyc(t + 10);
      t = cyc;
      ex(t + 1, "z_enter", 2'd3, 1, 1, 1, 0);
      ex(t + 5, "z_s2", 2'd2, 1, 1, 1, 0);
      ex(t + 9, "z_s1", 2'd1, 1, 1, 1, 0);
      ex(t + 13, "z_idle", 2'd0, 0, 1, 0, 1);
      pulse_cmd(2'd0, 1'b1);
      wait_cyc(t + 15);

      // estop during ramp-up with a command pending
      t = cyc;
      ex(t + 5, "es_s1", 2'd1, 1, 1, 1, 0);
      pulse_cmd(2'd2, 1'b1);
      wait_cyc(t + 6);
      estop     = 1'b1;
      cmd_valid = 1'b1;
      cmd_speed = 2'd3;
      cmd_dir   = 1'b0;
      ex(t + 7, "es_stop", 2'd0, 0, 1, 0, 0);
      wait_cyc(t + 7);
      estop     = 1'b0;
      cmd_valid = 1'b0;
      ex(t + 8, "es_ready", 2'd0, 0, 1, 0, 1);
      ex(t + 12, "es_stay_idle", 2'd0, 0, 1, 0, 1);
      wait_cyc(t + 13);

      // reset in the middle of dead time
      t = cyc;
      ex(t + 1, "dt_enter", 2'd0, 0, 1, 1, 0);
      pulse_cmd(2'd1, 1'b0);
      wait_cyc(t + 2);
      reset = 1'b1;
      ex(t + 3, "dt_reset", 2'd0, 0, 0, 0, 1);
      wait_cyc(t + 3);
      reset = 1'b0;
      ex(t + 4, "dt_rel", 2'd0, 0, 0, 0, 1);
      ex(t + 8, "dt_no_resid", 2'd0, 0, 0, 0, 1);
      wait_cyc(t + 10);

      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL queue_drain left=%0d want=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d want=finished", cyc);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/motor_ramp_sequencer.md
MOTOR_RAMP_SEQUENCER -- requirements
Module: motor_ramp_sequencer

Interface
REQ-001 SHALL have parameter: RAMP_TICKS, 1000000, clk cycles between successive one-step speed changes.
REQ-002 SHALL have parameter: DEAD_TICKS, 500000, clk cycles of zero drive before a direction change.
REQ-003 SHALL have port: clk  input  1  rising-edge system clock.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: cmd_valid  input  1  new motion command present.
REQ-006 SHALL have port: cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a clk edge.
REQ-007 SHALL have port: cmd_speed  input  2  target speed code, 0..3.
REQ-008 SHALL have port: cmd_dir  input  1  target direction, 0 = forward, 1 = reverse.
REQ-009 SHALL have port: estop  input  1  emergency stop, level-sensitive.
REQ-010 SHALL have port: pwm_speed  output  2  speed code driven to the PWM source.
REQ-011 SHALL have port: pwm_on  output  1  PWM source enable.
REQ-012 SHALL have port: motor_dir  output  1  H-bridge direction.
REQ-013 SHALL have port: busy  output  1  high in RAMP_UP, RAMP_DOWN and DEADTIME.

Function
REQ-014 SHALL implement FSM states IDLE, RAMP_UP, RAMP_DOWN, DEADTIME and HOLD; all outputs registered.
REQ-015 SHALL assert cmd_ready only in IDLE or HOLD with estop low; no command is accepted while busy.
REQ-016 SHALL latch cmd_speed and cmd_dir into target_speed and target_dir on acceptance.
REQ-017 On acceptance, SHALL go to RAMP_DOWN if cmd_dir != motor_dir and pwm_speed != 0.
REQ-018 On acceptance, SHALL go to DEADTIME if cmd_dir != motor_dir and pwm_speed == 0.
REQ-019 On acceptance with same direction: cmd_speed > pwm_speed goes to RAMP_UP; cmd_speed < pwm_speed goes to RAMP_DOWN.
REQ-020 On acceptance with same direction and equal speed: SHALL go to HOLD if speed != 0, else IDLE.
REQ-021 SHALL clear the tick counter on every state entry; the counter counts 0..RAMP_TICKS-1 (or 0..DEAD_TICKS-1 in DEADTIME).
REQ-022 RAMP_UP: SHALL increment pwm_speed by 1 when the counter wraps; first step comes RAMP_TICKS cycles after entry.
REQ-023 RAMP_UP: on pwm_speed reaching target_speed, SHALL go to HOLD.
REQ-024 RAMP_DOWN: SHALL decrement pwm_speed by 1 on each counter wrap.
REQ-025 RAMP_DOWN: on reaching 0 with a direction change pending, SHALL go to DEADTIME.
REQ-026 RAMP_DOWN: on reaching target_speed, SHALL go to HOLD, or to IDLE if the target is 0.
REQ-027 DEADTIME: pwm_speed SHALL be 0; after DEAD_TICKS cycles SHALL load motor_dir from target_dir in the same cycle as the exit transition.
REQ-028 DEADTIME exit SHALL go to RAMP_UP if target_speed != 0, else IDLE.
REQ-029 pwm_speed SHALL change by at most 1 per step, never wrap (no 3->0 or 0->3), and stay within 0..3.
REQ-030 pwm_on SHALL equal (pwm_speed != 0), registered together with pwm_speed.
REQ-031 motor_dir SHALL change only on DEADTIME exit and never while pwm_speed != 0.
REQ-032 estop high SHALL, on the next edge, force pwm_speed = 0, pwm_on = 0, target_speed = 0, state IDLE and counter = 0; motor_dir holds.
REQ-033 estop SHALL take priority over cmd_valid in the same cycle; that command is not accepted.
REQ-034 After estop deasserts, the block SHALL stay in IDLE until a new command is accepted.

Reset
REQ-035 Reset SHALL have priority over estop and all other inputs.
REQ-036 Reset SHALL set state IDLE, pwm_speed 0, pwm_on 0, motor_dir 0, busy 0, counter 0, target_speed 0 and target_dir 0.
REQ-037 Reset mid-ramp or mid-deadtime SHALL abort immediately with no residual step.
REQ-038 cmd_ready SHALL be 1 in the first cycle after reset release.

Verification (RAMP_TICKS=4, DEAD_TICKS=3)
REQ-039 Ramp up: from IDLE, cmd speed=3 dir=0 -> pwm_speed 1, 2, 3 at 4, 8 and 12 cycles after acceptance; then HOLD, busy=0, cmd_ready=1.
REQ-040 Reversal: in HOLD at speed 2 dir 0, cmd speed=1 dir=1 -> speed 1 then 0 (4-cycle spacing), 3 cycles DEADTIME, motor_dir=1, speed 1 four cycles later.
REQ-041 Ramp to zero: in HOLD at speed 3, cmd speed=0 same dir -> steps 2, 1, 0, then IDLE with pwm_on=0.
REQ-042 Estop: estop asserted during RAMP_UP at speed 1, with cmd_valid also high -> next cycle speed 0, IDLE, cmd_ready=0, command dropped.
REQ-043 Busy drop: cmd_valid held during RAMP_UP -> cmd_ready stays 0 and the command is not accepted until HOLD.
REQ-044 Reset mid-deadtime: reset pulsed during DEADTIME -> all outputs at reset values, motor_dir=0, IDLE.
